prod_accumulator: RTL
=====================

Name: prod_accumulator

Overview:
- Downstream stage of the 8x8 approximate multiplier.
- Registers the 16-bit product stream, sums the products of one group (dot-product / MAC style) and presents one accumulated result per group over a valid/ready handshake.
- Sits between the combinational multiplier plus its operand register and the result consumer.
- Lets approximate-multiplier error be evaluated at accumulated-sum level.

Parameters:
- PROD_W, 16, product width from the multiplier.
- ACC_W, 24, accumulator width; must be >= PROD_W.
- MAX_LEN, 256, maximum beats per group; CNT_W = $clog2(MAX_LEN+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_prod and in_last are valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- in_last  input  1  final beat of the current group.
- out_valid  output  1  group result available.
- out_ready  input  1  consumer takes the result.
- out_acc  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  beats in the group.
- out_ovf  output  1  accumulator carry-out occurred in the group.
- out_trunc  output  1  group ended by reaching MAX_LEN, not by in_last.

Behaviour:
- All state updates on the rising edge of clk.
- **Accept rule:** a beat is accepted when in_valid && in_ready.
- **Reset** (synchronous, wins over every other event):
  - state = IDLE; acc, cnt, out_ovf, out_trunc = 0; out_valid = 0.
  - in_ready = 0 while rst is high.
  - A reset mid-group discards the partial sum. No result is emitted.
- **in_ready:** combinational, = !rst && (state != HOLD).
- **FSM IDLE:**
  - On accept: acc = zero-extended in_prod, cnt = 1, ovf = 0.
  - Go to HOLD if in_last or MAX_LEN == 1; else go to ACCUM.
- **FSM ACCUM:**
  - On accept: acc = acc + in_prod (ACC_W+1-bit add), cnt = cnt + 1, ovf |= carry.
  - Go to HOLD if in_last, or if the new cnt == MAX_LEN. In the MAX_LEN case, out_trunc = 1 unless in_last is also set.
  - Cycles with no accept hold all state (gaps are allowed).
- **FSM HOLD:**
  - out_valid = 1. out_acc, out_count, out_ovf and out_trunc are stable and unchanged.
  - in_ready = 0.
  - On out_ready, go to IDLE next cycle, with out_valid = 0 and out_trunc cleared.
- **Latency:** out_valid rises the cycle after the last beat is accepted. At least one idle cycle separates groups (no same-cycle bypass).
- **Outputs:** out_acc, out_count and out_ovf are registered and mirror the internal acc, cnt and ovf.
- **Arithmetic:**
  - Unsigned.
  - Without the optional feature, the sum wraps modulo 2^ACC_W.
  - out_ovf is sticky per group.
- **Boundaries:**
  - in_last on the first beat: a 1-beat group.
  - in_valid while in HOLD: ignored (not accepted).
  - out_ready while not in HOLD: ignored.

Optional Feature:
- Macro: ACC_SAT_EN.
- **Defined:** on carry-out, acc clamps to all-ones (2^ACC_W-1) and holds there for the rest of the group; out_ovf is still set.
- **Undefined:** wrap-around arithmetic as above.
- **Either case:** width and handshake are identical.

Test Plan:
- **Basic group:** beats 0x0010, 0x0020, 0x0030, 0x0040, in_last on the 4th.
  - out_valid the next cycle; out_acc=0x0000A0, out_count=4, out_ovf=0, out_trunc=0.
- **Single beat:** in IDLE, in_prod=0x1234 with in_last.
  - out_acc=0x001234, out_count=1; back to IDLE one cycle after out_ready.
- **Backpressure and gaps:**
  - in_valid low for 3 cycles between beats: sum unaffected.
  - out_ready held low 5 cycles in HOLD: outputs stable, in_ready=0, offered beats not accepted.
  - Then out_ready=1: the next group starts from 0.
- **Overflow, ACC_W=17:** three beats of 0xFFFF, last on the 3rd.
  - Wrap build: out_acc=0x0FFFD, out_ovf=1.
  - ACC_SAT_EN build: out_acc=0x1FFFF, out_ovf=1.
- **Truncation:** 256 beats of 0xFFFF, no in_last.
  - Group closes at beat 256; out_acc=0xFFFF00, out_count=256, out_trunc=1, out_ovf=0.
- **Reset mid-group:** 2 beats accepted, then rst for 1 cycle.
  - out_valid=0, in_ready=0 during reset.
  - Next group 0x0005 with last: out_acc=0x000005, out_count=1.

Source files
------------

// File: rtl/prod_acc_if.sv
// Product-stream / group-result handshake bundle for prod_accumulator.
// The master side drives beats and out_ready; the slave side (the accumulator) drives the results.
interface prod_acc_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;
    logic              out_trunc;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf, out_trunc
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf, out_trunc
    );
endinterface

// File: rtl/prod_accumulator.sv
// Sums one group of unsigned multiplier products and hands the total out over valid/ready.
// Optional macro ACC_SAT_EN: clamp the sum to all-ones on carry-out instead of wrapping.
module prod_accumulator #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input logic       clk,
    input logic       rst,
    prod_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              trunc_q, trunc_d;
    logic              in_ready;
    logic              accept;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;

    assign prod = bus.in_prod;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        trunc_d  = trunc_q;
        in_ready = !rst && (state_q != HOLD);
        accept   = bus.in_valid && in_ready;
        // Extra top bit captures the carry-out of this beat.
        sum      = {1'b0, acc_q} + (ACC_W + 1)'(prod);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    trunc_d = !bus.in_last && (MAX_LEN == 1);
                    state_d = (bus.in_last || MAX_LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | sum[ACC_W];
`ifdef ACC_SAT_EN
                    // Once clamped, any non-zero beat carries again, so the sum stays pinned.
                    acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    if (bus.in_last || cnt_d == MAX_CNT) begin
                        state_d = HOLD;
                        trunc_d = !bus.in_last;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_trunc = trunc_q;
endmodule
